// File: rtl/neuron_mac_datapath.sv
// ---------------------------------------------------------------------------
// neuron_mac_datapath
//   Pair memory, threshold assembly, 3-stage multiply-accumulate and fire
//   decision for one neuron. It sits directly downstream of control_unit.
//
//   Optional feature (macro RELU_EN): when defined, acc_out and the fire
//   comparison both use max(acc, 0). The internal accumulator stays signed.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   rst_mem             one-cycle clear of acc, acc_sat, fire, pipeline tags
//   wr_en, wr_data_ptr  pair write strobe and address
//   data_in, weight_in  signed operands (data_in also carries threshold bytes)
//   threshold_ready     threshold byte strobe (low byte first, then high byte)
//   mul_mem_en          issue a read/multiply at rd_data_ptr
//   ac_mem_en           accumulate tag that travels with the issue
//   rd_data_ptr         read address
//   output_ready        result-request level; its rising edge triggers a decision
//   acc_out             accumulator (clamped to >= 0 with RELU_EN)
//   threshold_out       assembled 16-bit threshold
//   neuron_fire         sticky decision: acc >= threshold (signed)
//   result_valid        one-cycle pulse when neuron_fire is updated
//   acc_sat             sticky saturation flag
// ---------------------------------------------------------------------------
module neuron_mac_datapath #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ACC_W  = 24,
   parameter int unsigned DEPTH  = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      rst_mem,
   input  logic                      wr_en,
   input  logic [$clog2(DEPTH)-1:0]  wr_data_ptr,
   input  logic [DATA_W-1:0]         data_in,
   input  logic [DATA_W-1:0]         weight_in,
   input  logic                      threshold_ready,
   input  logic                      mul_mem_en,
   input  logic                      ac_mem_en,
   input  logic [$clog2(DEPTH)-1:0]  rd_data_ptr,
   input  logic                      output_ready,
   output logic [ACC_W-1:0]          acc_out,
   output logic [15:0]               threshold_out,
   output logic                      neuron_fire,
   output logic                      result_valid,
   output logic                      acc_sat
);

   localparam int unsigned PAIR_W = 2 * DATA_W;
   localparam int unsigned PROD_W = 2 * DATA_W;
   localparam int unsigned SUM_W  = ACC_W + 1;
   localparam int unsigned CMP_W  = (ACC_W > 16) ? ACC_W : 16;
   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic [PAIR_W-1:0] mem [DEPTH];

   logic [PAIR_W-1:0] pair_q, pair_d;
   logic [PROD_W-1:0] prod_q, prod_d;
   logic              s1_v_q, s1_v_d, s1_ac_q, s1_ac_d;
   logic              s2_v_q, s2_v_d, s2_ac_q, s2_ac_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [ACC_W-1:0]  acc_out_q, acc_out_d;
   logic              acc_sat_q, acc_sat_d;
   logic [15:0]       thr_q, thr_d;
   logic              byte_hi_q, byte_hi_d;
   logic              ordy_hist_q, ordy_hist_d;
   logic              fire_q, fire_d;
   logic              rvalid_q, rvalid_d;

   logic              mem_we;
   logic [SUM_W-1:0]  sum;
   logic signed [CMP_W-1:0] acc_cmp, thr_cmp;

   // Writes yield to threshold strobes and to issues.
   assign mem_we = wr_en & ~threshold_ready & ~mul_mem_en;

   // Pair storage; contents survive both resets.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[wr_data_ptr] <= {data_in, weight_in};
      end
   end

   // Datapath registers that need no reset (qualified by the valid tags).
   always_ff @(posedge clk) begin
      pair_q <= pair_d;
      prod_q <= prod_d;
   end

   // Next-state logic for the pipeline, accumulator, threshold and decision.
   always_comb begin
      pair_d      = pair_q;
      prod_d      = prod_q;
      s1_v_d      = mul_mem_en;
      s1_ac_d     = ac_mem_en;
      s2_v_d      = s1_v_q;
      s2_ac_d     = s1_ac_q;
      acc_d       = acc_q;
      acc_sat_d   = acc_sat_q;
      thr_d       = thr_q;
      byte_hi_d   = byte_hi_q;
      ordy_hist_d = output_ready;
      fire_d      = fire_q;
      rvalid_d    = 1'b0;

      // S1: registered read (old data on a same-cycle write)
      if (mul_mem_en) begin
         pair_d = mem[rd_data_ptr];
      end

      // S2: full-width signed product
      if (s1_v_q) begin
         prod_d = PROD_W'($signed(pair_q[PAIR_W-1:DATA_W])) *
                  PROD_W'($signed(pair_q[DATA_W-1:0]));
      end

      // S3: saturating accumulate; one guard bit detects overflow
      sum = {acc_q[ACC_W-1], acc_q} + SUM_W'($signed(prod_q));
      if (s2_v_q && s2_ac_q) begin
         if (sum[SUM_W-1] != sum[ACC_W-1]) begin
            acc_d     = sum[SUM_W-1] ? ACC_MIN : ACC_MAX;
            acc_sat_d = 1'b1;
         end else begin
            acc_d = sum[ACC_W-1:0];
         end
      end

      // Threshold bytes alternate low/high
      if (threshold_ready) begin
         if (byte_hi_q) begin
            thr_d[15:8] = 8'(data_in);
         end else begin
            thr_d[7:0]  = 8'(data_in);
         end
         byte_hi_d = ~byte_hi_q;
      end

      // Decision on output_ready rising; acc_out_q already holds the view value
      acc_cmp = CMP_W'($signed(acc_out_q));
      thr_cmp = CMP_W'($signed(thr_q));
      if (output_ready && !ordy_hist_q) begin
         fire_d   = (acc_cmp >= thr_cmp);
         rvalid_d = 1'b1;
      end

      // rst_mem wins over accumulate, decision and byte sequencing
      if (rst_mem) begin
         s1_v_d    = 1'b0;
         s2_v_d    = 1'b0;
         acc_d     = '0;
         acc_sat_d = 1'b0;
         fire_d    = 1'b0;
         rvalid_d  = 1'b0;
         byte_hi_d = 1'b0;
      end

`ifdef RELU_EN
      acc_out_d = acc_d[ACC_W-1] ? '0 : acc_d;
`else
      acc_out_d = acc_d;
`endif
   end

   // Control and result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_v_q      <= 1'b0;
         s1_ac_q     <= 1'b0;
         s2_v_q      <= 1'b0;
         s2_ac_q     <= 1'b0;
         acc_q       <= '0;
         acc_out_q   <= '0;
         acc_sat_q   <= 1'b0;
         thr_q       <= '0;
         byte_hi_q   <= 1'b0;
         ordy_hist_q <= 1'b0;
         fire_q      <= 1'b0;
         rvalid_q    <= 1'b0;
      end else begin
         s1_v_q      <= s1_v_d;
         s1_ac_q     <= s1_ac_d;
         s2_v_q      <= s2_v_d;
         s2_ac_q     <= s2_ac_d;
         acc_q       <= acc_d;
         acc_out_q   <= acc_out_d;
         acc_sat_q   <= acc_sat_d;
         thr_q       <= thr_d;
         byte_hi_q   <= byte_hi_d;
         ordy_hist_q <= ordy_hist_d;
         fire_q      <= fire_d;
         rvalid_q    <= rvalid_d;
      end
   end

   assign acc_out       = acc_out_q;
   assign threshold_out = thr_q;
   assign neuron_fire   = fire_q;
   assign result_valid  = rvalid_q;
   assign acc_sat       = acc_sat_q;

endmodule

// File: tb/tb_neuron_mac_datapath.sv
// ---------------------------------------------------------------------------
// tb_neuron_mac_datapath
//   Scoreboard bench. The stimulus process applies each cycle to a simple
//   arithmetic model (sum of issued products since the last clear, clamped)
//   and pushes the expected decision; a monitor pops on every result_valid.
// ---------------------------------------------------------------------------
module tb_neuron_mac_datapath;

   localparam longint ACC_MAX_V = 64'sd8388607;
   localparam longint ACC_MIN_V = -64'sd8388608;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rst_mem = 1'b0;
   logic        wr_en = 1'b0;
   logic [5:0]  wr_data_ptr = '0;
   logic [7:0]  data_in = '0;
   logic [7:0]  weight_in = '0;
   logic        threshold_ready = 1'b0;
   logic        mul_mem_en = 1'b0;
   logic        ac_mem_en = 1'b0;
   logic [5:0]  rd_data_ptr = '0;
   logic        output_ready = 1'b0;
   logic [23:0] acc_out;
   logic [15:0] threshold_out;
   logic        neuron_fire;
   logic        result_valid;
   logic        acc_sat;

   neuron_mac_datapath dut (
      .clk(clk), .rst_n(rst_n), .rst_mem(rst_mem), .wr_en(wr_en),
      .wr_data_ptr(wr_data_ptr), .data_in(data_in), .weight_in(weight_in),
      .threshold_ready(threshold_ready), .mul_mem_en(mul_mem_en),
      .ac_mem_en(ac_mem_en), .rd_data_ptr(rd_data_ptr),
      .output_ready(output_ready), .acc_out(acc_out),
      .threshold_out(threshold_out), .neuron_fire(neuron_fire),
      .result_valid(result_valid), .acc_sat(acc_sat)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint acc;
      bit     fire;
      bit     sat;
      int     thr;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // reference model state
   int     m_d [64];
   int     m_w [64];
   longint m_acc = 0;
   bit     m_sat = 0;
   bit     m_fire = 0;
   int     m_thr = 0;
   bit     m_hi = 0;
   bit     m_hist = 0;

   task automatic chk(input string name, input longint act, input longint expv);
      n_cmp++;
      if (act != expv) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   function automatic longint view(input longint a);
`ifdef RELU_EN
      return (a < 0) ? 0 : a;
`else
      return a;
`endif
   endfunction

   function automatic int sx8(input logic [7:0] b);
      return int'($signed(b));
   endfunction

   // Apply the current input values to the model for one clock cycle.
   task automatic model_apply();
      bit   rise;
      bit   nf;
      exp_t e;
      rise = output_ready && !m_hist && !rst_mem;
      m_hist = output_ready;
      nf = m_fire;
      if (rise) nf = (view(m_acc) >= longint'(int'($signed(16'(m_thr)))));
      if (mul_mem_en && ac_mem_en && !rst_mem) begin
         m_acc = m_acc + longint'(m_d[rd_data_ptr] * m_w[rd_data_ptr]);
         if (m_acc > ACC_MAX_V) begin m_acc = ACC_MAX_V; m_sat = 1; end
         if (m_acc < ACC_MIN_V) begin m_acc = ACC_MIN_V; m_sat = 1; end
      end
      if (wr_en && !threshold_ready && !mul_mem_en) begin
         m_d[wr_data_ptr] = sx8(data_in);
         m_w[wr_data_ptr] = sx8(weight_in);
      end
      if (threshold_ready) begin
         if (m_hi) m_thr = (m_thr & 16'h00ff) | (int'(data_in) << 8);
         else      m_thr = (m_thr & 16'hff00) | int'(data_in);
         m_hi = !m_hi;
      end
      m_fire = nf;
      if (rst_mem) begin
         m_acc = 0; m_sat = 0; m_fire = 0; m_hi = 0;
      end
      if (rise) begin
         e.acc = view(m_acc); e.fire = m_fire; e.sat = m_sat; e.thr = m_thr;
         exp_q.push_back(e);
      end
   endtask

   task automatic step();
      model_apply();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      rst_mem = 0; wr_en = 0; threshold_ready = 0;
      mul_mem_en = 0; ac_mem_en = 0; output_ready = 0;
   endtask

   task automatic idle(input int n);
      clr();
      repeat (n) step();
   endtask

   task automatic wr_pair(input int a, input int d, input int w);
      clr();
      wr_en = 1; wr_data_ptr = 6'(a); data_in = 8'(d); weight_in = 8'(w);
      step();
   endtask

   task automatic thr_byte(input int b);
      clr();
      threshold_ready = 1; data_in = 8'(b);
      step();
   endtask

   task automatic issue(input int a, input bit ac);
      clr();
      mul_mem_en = 1; ac_mem_en = ac; rd_data_ptr = 6'(a);
      step();
   endtask

   task automatic rmem();
      clr();
      rst_mem = 1;
      step();
   endtask

   // Drain the pipeline, hold output_ready for 'hold' cycles, await the result.
   task automatic decide(input int hold);
      int budget;
      idle(4);
      output_ready = 1;
      repeat (hold) step();
      idle(2);
      budget = 20;
      while (exp_q.size() != 0 && budget > 0) begin
         step();
         budget--;
      end
      if (exp_q.size() != 0) begin
         chk("result_timeout", longint'(exp_q.size()), 0);
         exp_q.delete();
      end
   endtask

   task automatic fill(input int d, input int w);
      for (int i = 0; i < 64; i++) wr_pair(i, d, w);
   endtask

   // Monitor: every result_valid pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && result_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result_valid", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("acc_out", longint'($signed(acc_out)), e.acc);
            chk("neuron_fire", longint'(neuron_fire), longint'(e.fire));
            chk("acc_sat", longint'(acc_sat), longint'(e.sat));
            chk("threshold_out", longint'(threshold_out), longint'(e.thr));
         end
      end
   end

   initial begin
      // reset
      rst_n = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_acc_out", longint'(acc_out), 0);
      chk("rst_threshold", longint'(threshold_out), 0);
      chk("rst_fire", longint'(neuron_fire), 0);
      chk("rst_result_valid", longint'(result_valid), 0);
      chk("rst_acc_sat", longint'(acc_sat), 0);
      rst_n = 1;
      idle(2);

      // 64 x (1*2) against threshold 128: equality fires
      fill(1, 2);
      thr_byte(8'h80); thr_byte(8'h00);
      for (int i = 0; i < 64; i++) issue(i, 1);
      decide(1);

      // 64 x (1*-1) against threshold 0
      rmem();
      fill(1, -1);
      thr_byte(0); thr_byte(0);
      for (int i = 0; i < 64; i++) issue(i, 1);
      decide(1);

      // positive saturation, then clear, then negative saturation
      rmem();
      fill(-128, -128);
      for (int i = 0; i < 600; i++) issue(i % 64, 1);
      decide(1);
      rmem();
      decide(1);
      fill(127, -128);
      for (int i = 0; i < 600; i++) issue(i % 64, 1);
      decide(2);

      // rst_mem mid-run: only post-pulse issues count
      rmem();
      for (int i = 0; i < 64; i++) wr_pair(i, i - 20, 3);
      for (int i = 0; i < 10; i++) issue(i + 40, 1);
      rmem();
      for (int i = 0; i < 12; i++) issue(i, 1);
      decide(1);

      // three threshold strobes; write blocked during a same-address read
      rmem();
      thr_byte(8'h11); thr_byte(8'h22); thr_byte(8'h33);
      wr_pair(5, 3, 4);
      clr();
      wr_en = 1; wr_data_ptr = 6'd5; data_in = 8'd9; weight_in = 8'd9;
      mul_mem_en = 1; ac_mem_en = 1; rd_data_ptr = 6'd5;
      step();
      issue(5, 1);
      decide(1);

      // ac_mem_en=0 issues are dropped; output_ready held high for 5 cycles
      rmem();
      for (int i = 0; i < 4; i++) issue(i, 0);
      for (int i = 4; i < 12; i++) issue(i, 1);
      decide(5);

      // randomized rounds
      for (int r = 0; r < 8; r++) begin
         if ($urandom_range(0, 1) == 1) rmem();
         repeat ($urandom_range(4, 16))
            wr_pair(int'($urandom_range(0, 63)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)));
         repeat ($urandom_range(0, 3)) thr_byte(int'($urandom_range(0, 255)));
         repeat ($urandom_range(1, 40)) begin
            clr();
            mul_mem_en = ($urandom_range(0, 7) != 0);
            ac_mem_en = 1'($urandom_range(0, 1));
            rd_data_ptr = 6'($urandom_range(0, 63));
            wr_en = 1'($urandom_range(0, 1));
            wr_data_ptr = 6'($urandom_range(0, 63));
            data_in = 8'($urandom_range(0, 255));
            weight_in = 8'($urandom_range(0, 255));
            rst_mem = ($urandom_range(0, 19) == 0);
            step();
         end
         decide(int'($urandom_range(1, 4)));
      end

      idle(3);
      chk("leftover_expectations", longint'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
